// File: rtl/rv32i_types.sv
// Shared types for the core's memory stage: byte-lane masks, responder FSM states
// and a lane-mask expander.
package rv32i_types;

    typedef logic [3:0] dmem_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_resp_state_t;

    function automatic logic [31:0] lane_mask(input dmem_mask_t m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port 32-bit word array with per-byte write enables and registered read.
// A same-cycle read and write of one word returns the word's previous contents.
module dmem_byte_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  re_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, services it against
// a byte-enabled array after LATENCY cycles and answers with a one-cycle resp.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h1ECE_B000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    dmem_resp_state_t      state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    dmem_mask_t            rmask_q;
    dmem_mask_t            wmask_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic                  resp_q;
    logic                  err_out_q;

    logic [31:0]           off;
    logic                  in_range;
    logic                  req_vld;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  accept;
    logic                  fire;
    logic                  cur_err;
    dmem_mask_t            cur_rmask;
    dmem_mask_t            cur_wmask;
    logic                  ram_re;
    logic [3:0]            ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    // Addresses below BASE_ADDR wrap to large offsets and fail the range test.
    assign off      = dmem_addr - BASE_ADDR;
    assign in_range = (off[31:DEPTH_LOG2+2] == '0);
    assign req_idx  = off[DEPTH_LOG2+1:2];
    assign req_vld  = (|dmem_rmask) | (|dmem_wmask);
    assign req_err  = !in_range | ((|dmem_rmask) & (|dmem_wmask));
    assign accept   = (state_q == IDLE) && req_vld;

    // The accept cycle counts as the first latency cycle, so the array is
    // touched on the last cycle before RESP; with LATENCY=1 that is the accept cycle.
    assign fire = ((state_q == WAIT) && (cnt_q <= 4'd1)) || (accept && (LATENCY == 1));

    always_comb begin
        cur_err   = err_q;
        cur_rmask = rmask_q;
        cur_wmask = wmask_q;
        ram_addr  = idx_q;
        ram_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_err   = req_err;
            cur_rmask = dmem_rmask;
            cur_wmask = dmem_wmask;
            ram_addr  = req_idx;
            ram_wdata = dmem_wdata;
        end
        ram_re = fire && !rst && !cur_err && (|cur_rmask);
        ram_we = (fire && !rst && !cur_err) ? cur_wmask : 4'b0000;
    end

    dmem_byte_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk_i  (clk),
        .re_i   (ram_re),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            rmask_q   <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            resp_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            resp_q    <= 1'b0;
            err_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        idx_q   <= req_idx;
                        rmask_q <= dmem_rmask;
                        wmask_q <= dmem_wmask;
                        wdata_q <= dmem_wdata;
                        err_q   <= req_err;
                        cnt_q   <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q   <= RESP;
                            resp_q    <= 1'b1;
                            err_out_q <= req_err;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q     <= 4'd0;
                        state_q   <= RESP;
                        resp_q    <= 1'b1;
                        err_out_q <= err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Only registered state feeds the outputs; stores and errors return zero data.
    assign dmem_resp  = resp_q;
    assign dmem_err   = err_out_q;
    assign dmem_rdata = (resp_q && !err_out_q) ? (ram_rdata & lane_mask(rmask_q)) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 and one LATENCY=3 instance
// share the request inputs but have separate resets.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h1ECE_B000;

    logic        clk;
    logic        rst2, rst3;
    logic [31:0] addr;
    logic [3:0]  rmask, wmask;
    logic [31:0] wdata;
    logic [31:0] rd2, rd3;
    logic        resp2, resp3, err2, err3;

    int nchk  = 0;
    int npass = 0;
    int cyc   = 0;
    int npulse2 = 0;
    int npulse3 = 0;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(BASE)) u2 (
        .clk(clk), .rst(rst2), .dmem_addr(addr), .dmem_rmask(rmask),
        .dmem_wmask(wmask), .dmem_wdata(wdata), .dmem_rdata(rd2),
        .dmem_resp(resp2), .dmem_err(err2)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(3), .BASE_ADDR(BASE)) u3 (
        .clk(clk), .rst(rst3), .dmem_addr(addr), .dmem_rmask(rmask),
        .dmem_wmask(wmask), .dmem_wdata(wdata), .dmem_rdata(rd3),
        .dmem_resp(resp3), .dmem_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resp2) npulse2 <= npulse2 + 1;
        if (resp3) npulse3 <= npulse3 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
        addr = a; rmask = rm; wmask = wm; wdata = wd;
    endtask

    task automatic clear();
        addr = 32'h0; rmask = 4'h0; wmask = 4'h0; wdata = 32'h0;
    endtask

    task automatic wait_resp(input bit s3, output int lat, output logic [31:0] rd,
                             output logic er, output int at);
        lat = 99; rd = 32'hBAD0_BAD0; er = 1'bx; at = -1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (s3 ? resp3 : resp2) begin
                lat = n;
                rd  = s3 ? rd3 : rd2;
                er  = s3 ? err3 : err2;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic req(input bit s3, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er, output int at);
        drive(a, rm, wm, wd);
        wait_resp(s3, lat, rd, er, at);
        clear();
    endtask

    initial begin
        int lat, at, at0, p0;
        logic [31:0] rd;
        logic er;

        clear();
        rst2 = 1'b1; rst3 = 1'b1;
        tick(); tick();
        rst2 = 1'b0; rst3 = 1'b0;

        // Reset state held while idle
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outputs", {resp2, err2, 30'h0} | rd2, 32'h0);
        end

        // Full-word store then load of the same word
        req(0, BASE + 32'd8, 4'h0, 4'hF, 32'hDEAD_BEEF, lat, rd, er, at0);
        chk("store_lat", 32'(lat), 32'd2);
        chk("store_rdata", rd, 32'h0);
        chk("store_err", {31'h0, er}, 32'h0);
        tick();
        req(0, BASE + 32'd8, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("load_lat", 32'(lat), 32'd2);
        chk("load_rdata", rd, 32'hDEAD_BEEF);
        chk("store_load_spacing", 32'(at - at0), 32'd3);
        tick();
        chk("resp_one_cycle", {31'h0, resp2}, 32'h0);

        // Byte merge into an existing word
        req(0, BASE + 32'h10, 4'h0, 4'hF, 32'h1122_3344, lat, rd, er, at);
        tick();
        req(0, BASE + 32'h10, 4'h0, 4'b0100, 32'h00AA_0000, lat, rd, er, at);
        tick();
        req(0, BASE + 32'h10, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("merge_full", rd, 32'h11AA_3344);
        tick();
        req(0, BASE + 32'h10, 4'b0011, 4'h0, 32'h0, lat, rd, er, at);
        chk("merge_low_lanes", rd, 32'h0000_3344);
        tick();

        // Request held through RESP is accepted again only afterwards
        p0 = npulse2;
        drive(BASE + 32'd8, 4'hF, 4'h0, 32'h0);
        wait_resp(0, lat, rd, er, at0);
        chk("hold_first_lat", 32'(lat), 32'd2);
        tick();
        chk("hold_no_reaccept", {31'h0, resp2}, 32'h0);
        wait_resp(0, lat, rd, er, at);
        clear();
        chk("hold_second_spacing", 32'(at - at0), 32'd3);
        chk("hold_second_rdata", rd, 32'hDEAD_BEEF);
        tick(); tick(); tick(); tick();
        chk("hold_pulse_count", 32'(npulse2 - p0), 32'd2);

        // Range boundaries
        req(0, BASE - 32'd4, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("below_base_err", {31'h0, er}, 32'h1);
        chk("below_base_rdata", rd, 32'h0);
        chk("below_base_lat", 32'(lat), 32'd2);
        tick();
        req(0, BASE + 32'd4096, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("past_end_err", {31'h0, er}, 32'h1);
        chk("past_end_rdata", rd, 32'h0);
        tick();
        req(0, BASE + 32'd4092, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("last_word_err", {31'h0, er}, 32'h0);
        tick();

        // Both masks set: error, memory untouched
        req(0, BASE + 32'd8, 4'hF, 4'hF, 32'h0, lat, rd, er, at);
        chk("both_masks_err", {31'h0, er}, 32'h1);
        chk("both_masks_rdata", rd, 32'h0);
        tick();
        req(0, BASE + 32'd8, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("both_masks_unchanged", rd, 32'hDEAD_BEEF);
        tick();

        // LATENCY=3: reset the cycle after a store is accepted
        rst3 = 1'b1;
        tick(); tick();
        rst3 = 1'b0;
        tick();
        req(1, BASE + 32'h20, 4'h0, 4'hF, 32'h5566_7788, lat, rd, er, at);
        chk("l3_store_lat", 32'(lat), 32'd3);
        tick(); tick();
        drive(BASE + 32'h20, 4'h0, 4'hF, 32'hCAFE_F00D);
        tick();
        rst3 = 1'b1;
        clear();
        tick();
        rst3 = 1'b0;
        p0 = npulse3;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_no_resp", 32'(npulse3 - p0), 32'd0);
        req(1, BASE + 32'h20, 4'hF, 4'h0, 32'h0, lat, rd, er, at);
        chk("rst_word_kept", rd, 32'h5566_7788);
        chk("rst_after_lat", 32'(lat), 32'd3);
        chk("rst_after_err", {31'h0, er}, 32'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time, as byte masks, a word-aligned address and write data. It services the request against an internal byte-enabled word array after a fixed, parameterised latency and answers with a single-cycle `dmem_resp` pulse. It sits opposite the pipeline's memory stage and replaces the magic memory in core-level simulation and small FPGA builds.

## Interface
Parameters:
- `DEPTH_LOG2`, 10, log2 of the number of 32-bit words in the array.
- `LATENCY`, 2, cycles from request accept to `dmem_resp`; legal range 1..15.
- `BASE_ADDR`, 32'h1ECE_B000, byte address of word 0; must be word-aligned.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `dmem_addr`  in  32  request byte address; bits [1:0] ignored.
- `dmem_rmask`  in  4  read byte-lane mask; nonzero means load.
- `dmem_wmask`  in  4  write byte-lane mask; nonzero means store.
- `dmem_wdata`  in  32  store data, already lane-aligned.
- `dmem_rdata`  out  32  load data, valid only while `dmem_resp` is high.
- `dmem_resp`  out  1  one-cycle completion pulse.
- `dmem_err`  out  1  asserted together with `dmem_resp` when the request was illegal.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Request valid means `|dmem_rmask | |dmem_wmask`.
- IDLE with a valid request (accept cycle):
  - Latch word index `(dmem_addr - BASE_ADDR) >> 2`, both masks and `dmem_wdata`.
  - Load the down-counter with `LATENCY-1`.
  - Go to WAIT, or straight to RESP when `LATENCY=1`.
- WAIT: decrement the counter each cycle. On the cycle the counter is 0:
  - Read the array into the rdata register.
  - Commit the latched write lanes (`wmask` bit i writes byte i).
  - Go to RESP.
- RESP: `dmem_resp=1` for exactly this one cycle, then go to IDLE.
- Inputs presented during WAIT or RESP are ignored. The initiator holds its request until it sees resp, so the request still visible in the RESP cycle must not be re-accepted. The next request is accepted no earlier than the cycle after RESP.
- `dmem_rdata` lanes:
  - Lanes with the latched `rmask` bit set carry array bytes; all other lanes are 0.
  - Stores return `dmem_rdata=0`.
- Illegal requests:
  - Address outside `[BASE_ADDR, BASE_ADDR + 4·2^DEPTH_LOG2)`, or rmask and wmask both nonzero.
  - Response: normal latency, `dmem_err=1` with resp, no array write, `dmem_rdata=0`.
- The array is not reset; contents are preserved across `rst`. It can be preloaded with `$readmemh` in simulation only.

## Timing
- Reset values: state IDLE; `dmem_resp=0`, `dmem_err=0`, `dmem_rdata=0`, counter 0, latched request cleared.
- Latency: accept at cycle T gives `dmem_resp` at cycle T+LATENCY.
- Throughput: at most one request per LATENCY+1 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- Store-then-load to the same word: the load sees the new data, because the write commits before the store's RESP cycle.
- `rst` during WAIT or RESP: return to IDLE next cycle, no resp is issued, and any pending write is discarded.
- Counter width is 4 bits; it never wraps because it stops at 0.
- Address subtraction is 32-bit unsigned. A request below `BASE_ADDR` underflows to a large value and is flagged out of range.

## Structure
- Put `dmem_resp_state_t` (IDLE/WAIT/RESP) in `rv32i_types`, next to the existing memory-stage typedefs.
- Sub-module `dmem_byte_ram`:
  - Single-port, 2^DEPTH_LOG2 × 32, 4 byte enables, synchronous read.
  - Read and write on the same address in the same cycle returns the old data; the responder never issues both at once.
- The FSM, counter, request latch and range check live in `dmem_responder`.

## Test plan
- Reset, then idle 5 cycles: `dmem_resp`, `dmem_err` and `dmem_rdata` stay 0.
- `LATENCY=2`: at T, store `BASE_ADDR+8`, wmask `4'b1111`, wdata `32'hDEADBEEF`. At T+3, load the same address, rmask `4'b1111`. Responses at T+2 and T+5; the load returns `32'hDEADBEEF`.
- Byte merge: `sb` with wmask `4'b0100`, wdata `32'h00AA0000` into a word holding `32'h11223344`. A load with rmask `4'b1111` then returns `32'h11AA3344`; a load with rmask `4'b0011` returns `32'h00003344`.
- Initiator holds the request through the RESP cycle and then re-presents the same load. Exactly one resp is produced per accepted request, and the second resp arrives LATENCY cycles after the cycle following the first resp.
- Out of range: a load at `BASE_ADDR-4` or `BASE_ADDR+4·2^DEPTH_LOG2` gives resp with `dmem_err=1` and rdata 0. A store with rmask and wmask both set gives err and leaves memory unchanged.
- Assert `rst` one cycle after accepting a store at `LATENCY=3`: no resp follows, the word keeps its old value, and a later request is serviced normally.
